// File: rtl/shift_pkg.sv
// Shared definitions for the RV32 shift execution unit: operation codes, widths
// and the bit-reversal helper used to turn right shifts into left shifts.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } shift_op_e;

  function automatic logic [XLEN-1:0] bitrev32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = 32'd0;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shamt_decoder.sv
// Combinational 5-to-32 one-hot decode of a shift amount; the single set bit
// is the power-of-two multiplier used by the shift datapath.
module shamt_decoder
  import shift_pkg::*;
(
  input  logic [SHAMT_W-1:0] shamt,
  output logic [XLEN-1:0]    onehot
);

  // Every code maps to exactly one set bit, so no latch can form.
  assign onehot = 32'd1 << shamt;

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage pipelined RV32 shift unit (SLL/SRL/SRA). Shifts are computed as
// operand x one-hot; right shifts reverse the operand in and the product out.
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  logic             s1_valid_r;
  shift_op_e        s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [XLEN-1:0]  s1_operand_r;
  logic             s1_sign_r;
  logic [XLEN-1:0]  s1_onehot_r;

  logic             s2_valid_r;
  logic [XLEN-1:0]  s2_data_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_err_r;

  logic [XLEN-1:0]  onehot_s;
  logic             s2_adv_s;
  logic             accept_s;
  logic [XLEN-1:0]  prod_s;
  logic [XLEN-1:0]  fill_s;
  logic [XLEN-1:0]  result_s;
  logic             err_s;

  shamt_decoder u_shamt_decoder (
    .shamt  (in_shamt),
    .onehot (onehot_s)
  );

  // Handshake: stage 2 frees itself by popping, stage 1 by advancing; no skid buffer.
  always_comb begin
    s2_adv_s = s1_valid_r && (!s2_valid_r || out_ready);
    in_ready = !s1_valid_r || s2_adv_s;
    accept_s = in_valid && in_ready && !flush;
  end

  // Result datapath: reserved ops yield zero data with the error flag set.
  always_comb begin
    prod_s   = s1_operand_r * s1_onehot_r;
    fill_s   = s1_sign_r ? bitrev32(s1_onehot_r - 32'd1) : 32'd0;
    result_s = 32'd0;
    err_s    = 1'b0;
    case (s1_op_r)
      OP_SLL:  result_s = prod_s;
      OP_SRL:  result_s = bitrev32(prod_s);
      OP_SRA:  result_s = bitrev32(prod_s) | fill_s;
      default: err_s    = 1'b1;
    endcase
  end

  // Stage 1 valid: flush wins, a fresh accept refills, otherwise empties on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 1 payload; right shifts pre-reverse the operand so one multiplier serves all ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_r      <= OP_SLL;
      s1_tag_r     <= '0;
      s1_operand_r <= 32'd0;
      s1_sign_r    <= 1'b0;
      s1_onehot_r  <= 32'd0;
    end else if (accept_s) begin
      s1_op_r      <= shift_op_e'(in_op);
      s1_tag_r     <= in_tag;
      s1_operand_r <= (in_op == OP_SLL) ? in_data : bitrev32(in_data);
      s1_sign_r    <= in_data[XLEN-1];
      s1_onehot_r  <= onehot_s;
    end else begin
      s1_op_r      <= s1_op_r;
      s1_tag_r     <= s1_tag_r;
      s1_operand_r <= s1_operand_r;
      s1_sign_r    <= s1_sign_r;
      s1_onehot_r  <= s1_onehot_r;
    end
  end

  // Stage 2 valid: a pop with a simultaneous advance keeps it full without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Stage 2 payload only moves on advance, so outputs hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_data_r <= 32'd0;
      s2_tag_r  <= '0;
      s2_err_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_data_r <= result_s;
      s2_tag_r  <= s1_tag_r;
      s2_err_r  <= err_s;
    end else begin
      s2_data_r <= s2_data_r;
      s2_tag_r  <= s2_tag_r;
      s2_err_r  <= s2_err_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_tag   = s2_tag_r;
  assign out_err   = s2_err_r;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed-vector bench for shift_exec_unit: hand-computed results, handshake,
// backpressure, flush, reserved op and asynchronous reset behaviour.
module tb_shift_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  int tests_run;
  int tests_failed;

  shift_exec_unit #(.TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                         input logic [4:0] tg);
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
    in_tag   = tg;
  endtask

  // One isolated request: accepted on the first edge, visible after the second, popped on the third.
  task automatic send_one(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [4:0] tg,
                          input logic [31:0] exp, input logic exp_err);
    out_ready = 1'b1;
    set_req(op, d, sh, tg);
    in_valid = 1'b1;
    #1;
    check({name, "_rdy"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check({name, "_v0"}, {31'd0, out_valid}, 32'd0);
    tick();
    check({name, "_v1"}, {31'd0, out_valid}, 32'd1);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tg});
    check({name, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    tick();
  endtask

  logic [31:0] exp_q [3];
  int          idx;
  int          got_n;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_req(2'b00, 32'd0, 5'd0, 5'd0);

    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_one("sll31",   2'b00, 32'h0000_0001, 5'd31, 5'd5,  32'h8000_0000, 1'b0);
    send_one("sra4",    2'b10, 32'h8000_0010, 5'd4,  5'd6,  32'hF800_0001, 1'b0);
    send_one("srl4",    2'b01, 32'h8000_0010, 5'd4,  5'd7,  32'h0800_0001, 1'b0);
    send_one("sra31",   2'b10, 32'h8000_0010, 5'd31, 5'd8,  32'hFFFF_FFFF, 1'b0);
    send_one("sra31p",  2'b10, 32'h7000_0000, 5'd31, 5'd9,  32'h0000_0000, 1'b0);
    send_one("srl31",   2'b01, 32'h8000_0000, 5'd31, 5'd10, 32'h0000_0001, 1'b0);
    send_one("sra0",    2'b10, 32'h8000_0010, 5'd0,  5'd11, 32'h8000_0010, 1'b0);
    send_one("srl0",    2'b01, 32'hA5A5_0F0F, 5'd0,  5'd12, 32'hA5A5_0F0F, 1'b0);
    send_one("sll0",    2'b00, 32'h1234_5678, 5'd0,  5'd13, 32'h1234_5678, 1'b0);
    send_one("sll8",    2'b00, 32'h1234_5678, 5'd8,  5'd14, 32'h3456_7800, 1'b0);
    send_one("reserved",2'b11, 32'h1234_5678, 5'd3,  5'd15, 32'h0000_0000, 1'b1);

    // Back-to-back: eight SLLs of 0xDEADBEEF with shamt 0..7, no backpressure.
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      set_req(2'b00, 32'hDEAD_BEEF, c[4:0], c[4:0]);
      #1;
      if (c < 8) check("b2b_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      check("b2b_valid", {31'd0, out_valid}, {31'd0, (c >= 1 && c <= 8)});
      if (c >= 1 && c <= 8) begin
        check("b2b_data", out_data, 32'hDEAD_BEEF << (c - 1));
        check("b2b_tag", {27'd0, out_tag}, c - 1);
      end
    end
    in_valid = 1'b0;

    // Backpressure: three SRL requests offered while the sink stalls for 5 cycles.
    exp_q[0] = 32'h4000_0000;
    exp_q[1] = 32'h2000_0000;
    exp_q[2] = 32'h1000_0000;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      set_req(2'b01, 32'h8000_0000, 5'(idx + 1), 5'(idx + 1));
      #1;
      if (in_ready) idx++;
      tick();
      if (c >= 2) begin
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_data", out_data, 32'h4000_0000);
        check("bp_hold_tag", {27'd0, out_tag}, 32'd1);
      end
    end
    check("bp_accepted", idx, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 3);
      set_req(2'b01, 32'h8000_0000, 5'(idx + 1), 5'(idx + 1));
      #1;
      if (out_valid && got_n < 3) begin
        check("bp_drain_data", out_data, exp_q[got_n]);
        check("bp_drain_tag", {27'd0, out_tag}, got_n + 1);
        got_n++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_drained", got_n, 32'd3);
    check("bp_third_accepted", idx, 32'd3);

    // Flush with both stages full and a new request in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(2'b00, 32'h0000_0003, 5'd1, 5'd1);
    tick();
    set_req(2'b00, 32'h0000_0003, 5'd2, 5'd2);
    tick();
    check("fl_full_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    set_req(2'b00, 32'h0000_0003, 5'd3, 5'd3);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("fl_valid_next", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("fl_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset between edges while a result is held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(2'b00, 32'h0000_0001, 5'd1, 5'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", {31'd0, out_valid}, 32'd0);
    check("ar_data_clr", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_still_idle", {31'd0, out_valid}, 32'd0);
    send_one("ar_first", 2'b00, 32'h0000_00F0, 5'd4, 5'd3, 32'h0000_0F00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
